// File: rtl/sweep_controller_if.sv
// Signal bundle between sweep_controller, its command source and the external up/down counter.
// slave is the controller's view; master is the environment (command source plus counter).
interface sweep_controller_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned PASS_W = 4
);
    logic              start;
    logic              stop;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [PASS_W-1:0] npass;
    logic              busy;
    logic              done;
    logic              err;
    logic [PASS_W-1:0] pass_cnt;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_dir;
    logic [WIDTH-1:0]  cnt_d;
    logic [WIDTH-1:0]  cnt_q;

    modport slave (
        input  start, stop, lo, hi, npass, cnt_q,
        output busy, done, err, pass_cnt, cnt_load, cnt_en, cnt_dir, cnt_d
    );

    modport master (
        output start, stop, lo, hi, npass, cnt_q,
        input  busy, done, err, pass_cnt, cnt_load, cnt_en, cnt_dir, cnt_d
    );
endinterface

// File: rtl/sweep_controller.sv
// Drives an external up/down counter through LO->HI->LO triangle sweeps for NPASS passes (0 = until STOP).
// Define SWEEP_DWELL_EN to hold the counter for DWELL cycles at each non-final turnaround.
module sweep_controller #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned PASS_W = 4,
    parameter int unsigned DWELL  = 2
) (
    input logic               clk,
    input logic               mr,
    sweep_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_UP, S_DOWN, S_DONE, S_DWELL_HI, S_DWELL_LO
    } state_e;

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
        $error("sweep_controller: DWELL must be 1..255");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [PASS_W-1:0] npass_q, npass_d, pass_cnt_q, pass_cnt_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              cnt_load_q, cnt_load_d, cnt_en_q, cnt_en_d, cnt_dir_q, cnt_dir_d;
    logic              range_fault, at_top, at_bottom, last_pass;
`ifdef SWEEP_DWELL_EN
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    logic [7:0]        dwell_cnt_q, dwell_cnt_d;
`endif

    // Turnaround decisions look at Q before the edge that moves the counter onto the endpoint.
    assign range_fault = (bus.cnt_q < lo_q) || (bus.cnt_q > hi_q);
    assign at_top      = (bus.cnt_q == hi_q - CNT_ONE);
    assign at_bottom   = (bus.cnt_q == lo_q + CNT_ONE);
    assign last_pass   = (npass_q != '0) && (pass_cnt_q + PASS_ONE == npass_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        npass_d    = npass_q;
        pass_cnt_d = pass_cnt_q;
        err_d      = 1'b0;
`ifdef SWEEP_DWELL_EN
        dwell_cnt_d = dwell_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                if (bus.lo < bus.hi) begin
                    lo_d       = bus.lo;
                    hi_d       = bus.hi;
                    npass_d    = bus.npass;
                    pass_cnt_d = '0;
                    state_d    = S_LOAD;
                end else begin
                    err_d = 1'b1;
                end
            end
            S_LOAD: state_d = bus.stop ? S_IDLE : S_UP;
            S_UP: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (range_fault) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (at_top) begin
`ifdef SWEEP_DWELL_EN
                    state_d     = S_DWELL_HI;
                    dwell_cnt_d = DWELL_LAST;
`else
                    state_d = S_DOWN;
`endif
                end
            end
            S_DOWN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (range_fault) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (at_bottom) begin
                    pass_cnt_d = pass_cnt_q + PASS_ONE;
                    if (last_pass) begin
                        state_d = S_DONE;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        state_d     = S_DWELL_LO;
                        dwell_cnt_d = DWELL_LAST;
`else
                        state_d = S_UP;
`endif
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
`ifdef SWEEP_DWELL_EN
            S_DWELL_HI, S_DWELL_LO: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (dwell_cnt_q == 8'd0) begin
                    state_d = (state_q == S_DWELL_HI) ? S_DOWN : S_UP;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 8'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every pin leaves a flop.
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        cnt_load_d = (state_d != S_LOAD);
        cnt_en_d   = (state_d == S_UP) || (state_d == S_DOWN);
        cnt_dir_d  = (state_d == S_DOWN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            state_q    <= S_IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            npass_q    <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_load_q <= 1'b1;
            cnt_en_q   <= 1'b0;
            cnt_dir_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            npass_q    <= npass_d;
            pass_cnt_q <= pass_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_load_q <= cnt_load_d;
            cnt_en_q   <= cnt_en_d;
            cnt_dir_q  <= cnt_dir_d;
        end
    end

`ifdef SWEEP_DWELL_EN
    always_ff @(posedge clk or negedge mr) begin
        if (!mr) dwell_cnt_q <= 8'd0;
        else     dwell_cnt_q <= dwell_cnt_d;
    end
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.cnt_load = cnt_load_q;
    assign bus.cnt_en   = cnt_en_q;
    assign bus.cnt_dir  = cnt_dir_q;
    assign bus.cnt_d    = lo_q;
endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller with a behavioural 4-bit up/down counter (async active-low load).
// Cycle tables cover single/multi-pass and reject; hand sequences cover reset, STOP and range fault.
`timescale 1ns/1ps
module tb_sweep_controller;
    localparam int WIDTH  = 4;
    localparam int PASS_W = 4;

    logic       clk    = 1'b0;
    logic       mr     = 1'b0;
    logic [3:0] q      = 4'd0;
    logic       q_kick = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    sweep_controller_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) bus ();

    sweep_controller #(.WIDTH(WIDTH), .PASS_W(PASS_W), .DWELL(2)) dut (
        .clk (clk),
        .mr  (mr),
        .bus (bus)
    );

    // External counter; q_kick forces an out-of-range jump to provoke a range fault.
    always @(posedge clk or negedge bus.cnt_load) begin
        if (!bus.cnt_load)   q <= bus.cnt_d;
        else if (q_kick)     q <= 4'hF;
        else if (bus.cnt_en) q <= bus.cnt_dir ? q - 4'd1 : q + 4'd1;
    end
    assign bus.cnt_q = q;

    typedef struct {
        string       name;
        bit          start;
        bit          stop;
        logic [3:0]  lo;
        logic [3:0]  hi;
        logic [3:0]  np;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected vector layout: {busy, done, err, load, en, dir, pass_cnt, cnt_d, q}
    function automatic vec_t mk(string name, int st, int sp, int lo, int hi, int np,
                                int busy, int done, int err, int ld, int en, int dir,
                                int pc, int cd, int qv);
        vec_t v;
        v.name  = name;
        v.start = 1'(st);
        v.stop  = 1'(sp);
        v.lo    = 4'(lo);
        v.hi    = 4'(hi);
        v.np    = 4'(np);
        v.exp   = {1'(busy), 1'(done), 1'(err), 1'(ld), 1'(en), 1'(dir), 4'(pc), 4'(cd), 4'(qv)};
        return v;
    endfunction

    function automatic logic [17:0] obs();
        return {bus.busy, bus.done, bus.err, bus.cnt_load, bus.cnt_en, bus.cnt_dir,
                bus.pass_cnt, bus.cnt_d, q};
    endfunction

    task automatic check(string name, logic [17:0] act, logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(bit st, bit sp, logic [3:0] lo, logic [3:0] hi, logic [3:0] np);
        @(negedge clk);
        bus.start = st;
        bus.stop  = sp;
        bus.lo    = lo;
        bus.hi    = hi;
        bus.npass = np;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

`ifdef SWEEP_DWELL_EN
        // LO=3 HI=5 NPASS=1 with DWELL=2: hold at HI, no dwell before DONE.
        tbl.push_back(mk("dw_load",  1,0,3,5,1, 1,0,0,0,0,0, 0,3,3));
        tbl.push_back(mk("dw_up0",   0,0,3,5,1, 1,0,0,1,1,0, 0,3,3));
        tbl.push_back(mk("dw_up1",   0,0,3,5,1, 1,0,0,1,1,0, 0,3,4));
        tbl.push_back(mk("dw_hold0", 0,0,3,5,1, 1,0,0,1,0,0, 0,3,5));
        tbl.push_back(mk("dw_hold1", 0,0,3,5,1, 1,0,0,1,0,0, 0,3,5));
        tbl.push_back(mk("dw_dn0",   0,0,3,5,1, 1,0,0,1,1,1, 0,3,5));
        tbl.push_back(mk("dw_dn1",   0,0,3,5,1, 1,0,0,1,1,1, 0,3,4));
        tbl.push_back(mk("dw_done",  0,0,3,5,1, 0,1,0,1,0,0, 1,3,3));
        tbl.push_back(mk("dw_idle",  0,0,3,5,1, 0,0,0,1,0,0, 1,3,3));
`else
        // LO=3 HI=6 NPASS=1; START and new bounds while busy are ignored.
        tbl.push_back(mk("p1_load",  1,0,3,6,1,  1,0,0,0,0,0, 0,3,3));
        tbl.push_back(mk("p1_up0",   0,0,3,6,1,  1,0,0,1,1,0, 0,3,3));
        tbl.push_back(mk("p1_up_ign",1,0,0,15,0, 1,0,0,1,1,0, 0,3,4));
        tbl.push_back(mk("p1_up2",   0,0,0,15,0, 1,0,0,1,1,0, 0,3,5));
        tbl.push_back(mk("p1_dn0",   0,0,3,6,1,  1,0,0,1,1,1, 0,3,6));
        tbl.push_back(mk("p1_dn1",   0,0,3,6,1,  1,0,0,1,1,1, 0,3,5));
        tbl.push_back(mk("p1_dn2",   0,0,3,6,1,  1,0,0,1,1,1, 0,3,4));
        tbl.push_back(mk("p1_done",  0,0,3,6,1,  0,1,0,1,0,0, 1,3,3));
        tbl.push_back(mk("p1_idle",  0,0,3,6,1,  0,0,0,1,0,0, 1,3,3));
        // LO=0 HI=1 NPASS=3: narrowest legal range, three passes.
        tbl.push_back(mk("n_load",   1,0,0,1,3,  1,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk("n_up0",    0,0,0,1,3,  1,0,0,1,1,0, 0,0,0));
        tbl.push_back(mk("n_dn0",    0,0,0,1,3,  1,0,0,1,1,1, 0,0,1));
        tbl.push_back(mk("n_up1",    0,0,0,1,3,  1,0,0,1,1,0, 1,0,0));
        tbl.push_back(mk("n_dn1",    0,0,0,1,3,  1,0,0,1,1,1, 1,0,1));
        tbl.push_back(mk("n_up2",    0,0,0,1,3,  1,0,0,1,1,0, 2,0,0));
        tbl.push_back(mk("n_dn2",    0,0,0,1,3,  1,0,0,1,1,1, 2,0,1));
        tbl.push_back(mk("n_done",   0,0,0,1,3,  0,1,0,1,0,0, 3,0,0));
        tbl.push_back(mk("n_idle",   0,0,0,1,3,  0,0,0,1,0,0, 3,0,0));
`endif
        // Rejected starts: LO==HI and LO>HI leave the latched run state alone.
        tbl.push_back(mk("rej_eq",   1,0,9,9,2,  0,0,1,1,0,0, 0,0,0));
        tbl.push_back(mk("rej_eq_1", 0,0,9,9,2,  0,0,0,1,0,0, 0,0,0));
        tbl.push_back(mk("rej_gt",   1,0,10,2,2, 0,0,1,1,0,0, 0,0,0));
        tbl.push_back(mk("rej_gt_1", 0,0,10,2,2, 0,0,0,1,0,0, 0,0,0));

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.lo    = 4'd0;
        bus.hi    = 4'd0;
        bus.npass = 4'd0;

        #12;
        check("reset_initial", obs(), {6'b000100, 4'd0, 4'd0, 4'd0});
        @(negedge clk);
        mr = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].name.substr(0, 2) == "rej") begin
                // Reject rows expect the latched state left by the preceding run.
`ifdef SWEEP_DWELL_EN
                tbl[i].exp[11:0] = {4'd1, 4'd3, 4'd3};
`else
                tbl[i].exp[11:0] = {4'd3, 4'd0, 4'd0};
`endif
            end
            step(tbl[i].start, tbl[i].stop, tbl[i].lo, tbl[i].hi, tbl[i].np);
            check(tbl[i].name, obs(), tbl[i].exp);
        end

        // STOP mid-DOWN at Q=10: next edge freezes Q at 9, no DONE.
        step(1'b1, 1'b0, 4'd2, 4'd14, 4'd0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (bus.cnt_dir && q == 4'd10) found = 1'b1;
            else step(1'b0, 1'b0, 4'd2, 4'd14, 4'd0);
        end
        check("stop_reach_q10", 18'(found), 18'd1);
        step(1'b0, 1'b1, 4'd2, 4'd14, 4'd0);
        check("stop_edge", obs(), {6'b000100, 4'd0, 4'd2, 4'd9});
        step(1'b0, 1'b0, 4'd2, 4'd14, 4'd0);
        check("stop_frozen", obs(), {6'b000100, 4'd0, 4'd2, 4'd9});

        // Range fault: counter jumps to 15 while sweeping 2..8.
        step(1'b1, 1'b0, 4'd2, 4'd8, 4'd0);
        step(1'b0, 1'b0, 4'd2, 4'd8, 4'd0);
        step(1'b0, 1'b0, 4'd2, 4'd8, 4'd0);
        q_kick = 1'b1;
        step(1'b0, 1'b0, 4'd2, 4'd8, 4'd0);
        q_kick = 1'b0;
        check("fault_jump", obs(), {6'b100110, 4'd0, 4'd2, 4'd15});
        step(1'b0, 1'b0, 4'd2, 4'd8, 4'd0);
        check("fault_err", obs(), {6'b001100, 4'd0, 4'd2, 4'd0});
        step(1'b0, 1'b0, 4'd2, 4'd8, 4'd0);
        check("fault_clear", obs(), {6'b000100, 4'd0, 4'd2, 4'd0});

        // Asynchronous reset mid-UP with Q=5: outputs clear at once, counter holds.
        step(1'b1, 1'b0, 4'd2, 4'd10, 4'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.cnt_en && !bus.cnt_dir && q == 4'd5) found = 1'b1;
            else step(1'b0, 1'b0, 4'd2, 4'd10, 4'd0);
        end
        check("reset_reach_q5", 18'(found), 18'd1);
        #2 mr = 1'b0;
        #1;
        check("reset_async", obs(), {6'b000100, 4'd0, 4'd0, 4'd5});
        step(1'b0, 1'b0, 4'd2, 4'd10, 4'd0);
        step(1'b0, 1'b0, 4'd2, 4'd10, 4'd0);
        check("reset_q_hold", obs(), {6'b000100, 4'd0, 4'd0, 4'd5});
        @(negedge clk);
        mr = 1'b1;
        step(1'b0, 1'b0, 4'd2, 4'd10, 4'd0);
        check("reset_release_idle", obs(), {6'b000100, 4'd0, 4'd0, 4'd5});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
